reaction_delay_timer: RTL
=========================

# reaction_delay_timer

Control stage downstream of the 4-bit LFSR in the reaction-timer design. On a start request it samples the LFSR value and converts it to a random pre-stimulus delay of BASE_MS + rand × STEP_MS milliseconds. It then lights the stimulus LED and measures the player's reaction time in whole milliseconds. It reports false starts and timeouts, and holds the result for the display stage.

## Interface
- TICKS_PER_MS, 50000, clock cycles per millisecond tick (≥2)
- BASE_MS, 1000, minimum pre-stimulus delay in ms
- STEP_MS, 250, delay added per LFSR count
- MAX_MS, 9999, reaction window limit; BASE_MS+15×STEP_MS and MAX_MS must each be ≤16383
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; forces all state and outputs to reset values immediately
- start  input  1  synchronous start request, sampled each cycle
- react  input  1  debounced, synchronized player button (level)
- rand_in  input  4  current LFSR value
- led  output  1  stimulus light
- busy  output  1  high in WAIT or GO
- done  output  1  one-cycle pulse when a result is committed
- early  output  1  false-start flag, held until next accepted start
- timeout  output  1  no-reaction flag, held until next accepted start
- result_ms  output  14  reaction time in ms, held until next accepted start

## Operation
- States: IDLE, WAIT, GO. Reset → IDLE; led, busy, done, early, timeout, result_ms = 0; prescaler, ms counter, delay register, react history = 0.
- React edge: react_prev register; edge = react & ~react_prev. A level held across state changes never counts.
- IDLE: start=1 → latch delay_ms = BASE_MS + rand_in×STEP_MS (14-bit, no overflow by parameter rule); clear early, timeout, result_ms; clear prescaler and ms counter; → WAIT. In IDLE, react edges are ignored. If start and a react edge occur in the same cycle, start wins.
- WAIT: the prescaler counts 0..TICKS_PER_MS-1 and wraps; on wrap the ms counter increments.
  - React edge → early=1, result_ms=0, done pulse, → IDLE. led never rises.
  - Otherwise, when the ms counter reaches delay_ms → led=1, prescaler and ms counter cleared, → GO.
- GO: same tick scheme.
  - React edge → result_ms = ms counter (completed ms since led rose), led=0, done pulse, → IDLE.
  - If the ms counter reaches MAX_MS with no react edge → timeout=1, result_ms=MAX_MS, led=0, done pulse, → IDLE.
  - A react edge in the same cycle the counter reaches MAX_MS counts as a reaction, with result MAX_MS and timeout=0.
- start is ignored in WAIT and GO.
- busy = (state≠IDLE), registered alongside state.
- Reset asserted mid-operation returns the block to IDLE with all outputs 0. No done pulse is issued.

## Timing
- Start accepted at clock edge E0: busy=1 after E0. led rises at edge E0 + delay_ms×TICKS_PER_MS.
- Reaction: react high at edge Er with react low at Er-1 → done, result_ms and led=0 all visible after Er; done low after Er+1. Result latency is one edge from the sampled edge.
- Counter ordering: the ms counter updates and the react check happen at the same edge. result_ms reflects the counter value before that edge's increment.
- done never asserts on two consecutive cycles. A start on the cycle after done is accepted.
- rand_in is sampled only at the accepting edge; later changes have no effect.

## Test plan
Bench parameters: TICKS_PER_MS=4, BASE_MS=2, STEP_MS=1, MAX_MS=20.
- Reset: hold reset=0 with start=1 and react toggling → all outputs 0. Release reset → IDLE, busy=0.
- Normal run: rand_in=3, start pulse at E0 → led=1 after edge E0+20. Raise react 28 cycles after the led rising edge → done pulse, result_ms=7, early=0, timeout=0, led=0, busy=0.
- False start: rand_in=15, start, react edge at E0+10 → early=1, result_ms=0, done pulse, led stays 0 throughout.
- Timeout: rand_in=0, start, no react → led rises at E0+8. After 80 further cycles: timeout=1, result_ms=20, done pulse, led=0.
- Held button and ignored start: react held high from before start → no early, WAIT completes. Pulse start during GO → ignored, delay unchanged. Release and re-press react → valid result.
- Reset mid-WAIT and simultaneous events: assert reset during WAIT → led=0, busy=0 immediately, no done. In IDLE, start and a react edge in the same cycle → WAIT entered, early=0.

Source files
------------

// File: rtl/reaction_delay_timer.sv
// reaction_delay_timer: random pre-stimulus delay from the LFSR, LED stimulus,
// and reaction time measured in whole milliseconds with false-start/timeout flags.
module reaction_delay_timer #(
   parameter int TICKS_PER_MS = 50000,
   parameter int BASE_MS      = 1000,
   parameter int STEP_MS      = 250,
   parameter int MAX_MS       = 9999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        react,
   input  logic [3:0]  rand_in,
   output logic        led,
   output logic        busy,
   output logic        done,
   output logic        early,
   output logic        timeout,
   output logic [13:0] result_ms
);
   localparam int PW = $clog2(TICKS_PER_MS);
   typedef enum logic [1:0] {IDLE, WAIT, GO} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [13:0] ms_cnt, ms_nxt, ms_inc, delay_ms, delay_nxt, result_nxt;
   logic react_prev, press, tick, hit_delay, hit_max;
   logic led_nxt, done_nxt, early_nxt, timeout_nxt;
   assign press     = react & ~react_prev;
   assign tick      = presc == PW'(TICKS_PER_MS - 1);
   assign ms_inc    = ms_cnt + {13'd0, tick};
   assign hit_delay = (state == WAIT) && (ms_inc == delay_ms);
   assign hit_max   = (state == GO) && (ms_inc == 14'(MAX_MS));
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= state_nxt != IDLE;
      end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? WAIT : IDLE;
         WAIT:    state_nxt = press ? IDLE : hit_delay ? GO : WAIT;
         GO:      state_nxt = (press || hit_max) ? IDLE : GO;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      presc_nxt   = tick ? '0 : presc + PW'(1);
      ms_nxt      = ms_inc;
      delay_nxt   = delay_ms;
      led_nxt     = led;
      done_nxt    = 1'b0;
      early_nxt   = early;
      timeout_nxt = timeout;
      result_nxt  = result_ms;
      case (state)
         IDLE: begin
            presc_nxt = '0;
            ms_nxt    = '0;
            if (start) begin
               delay_nxt   = 14'(BASE_MS) + 14'(rand_in) * 14'(STEP_MS);
               early_nxt   = 1'b0;
               timeout_nxt = 1'b0;
               result_nxt  = '0;
            end
         end
         WAIT: begin
            if (press) begin
               early_nxt  = 1'b1;
               result_nxt = '0;
               done_nxt   = 1'b1;
            end else if (hit_delay) begin
               led_nxt   = 1'b1;
               presc_nxt = '0;
               ms_nxt    = '0;
            end
         end
         GO: begin
            // a press on the limit edge is a reaction scored at the limit
            if (press || hit_max) begin
               led_nxt     = 1'b0;
               done_nxt    = 1'b1;
               result_nxt  = hit_max ? 14'(MAX_MS) : ms_cnt;
               timeout_nxt = hit_max & ~press;
            end
         end
         default: begin
            presc_nxt = '0;
            ms_nxt    = '0;
         end
      endcase
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         presc      <= '0;
         ms_cnt     <= '0;
         delay_ms   <= '0;
         react_prev <= 1'b0;
         led        <= 1'b0;
         done       <= 1'b0;
         early      <= 1'b0;
         timeout    <= 1'b0;
         result_ms  <= '0;
      end else begin
         presc      <= presc_nxt;
         ms_cnt     <= ms_nxt;
         delay_ms   <= delay_nxt;
         react_prev <= react;
         led        <= led_nxt;
         done       <= done_nxt;
         early      <= early_nxt;
         timeout    <= timeout_nxt;
         result_ms  <= result_nxt;
      end
endmodule
